// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding, command bytes and result byte selection for the scan sequencer
package scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG     = 3'd1,
        S_SET_DAC = 3'd2,
        S_SETTLE  = 3'd3,
        S_MEASURE = 3'd4,
        S_SEND    = 3'd5,
        S_NEXT    = 3'd6
    } state_t;

    localparam logic [7:0] ARM_BYTE   = 8'hA5;
    localparam logic [7:0] ABORT_BYTE = 8'h5A;

    // Result record for one step: the DAC code first, then the hit count MSB first.
    function automatic logic [7:0] result_byte(input logic [2:0] idx,
                                               input logic [7:0] code,
                                               input logic [31:0] count);
        case (idx)
            3'd0:    result_byte = code;
            3'd1:    result_byte = count[31:24];
            3'd2:    result_byte = count[23:16];
            3'd3:    result_byte = count[15:8];
            default: result_byte = count[7:0];
        endcase
    endfunction

endpackage

// File: rtl/hit_counter.sv
// rtl/hit_counter.sv - synchronizes the discriminator output and counts its rising edges, saturating
module hit_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        hit,
    output logic [31:0] count
);

    logic        sync1;
    logic        sync2;
    logic        prev;
    logic        rise;
    logic [31:0] count_next;

    // Two-flop synchronizer plus one delayed copy for edge detection; runs in every state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= hit;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // Clear wins over counting; the count sticks at all-ones instead of wrapping.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = 32'd0;
        end else if (en && rise && (count != 32'hFFFF_FFFF)) begin
            count_next = count + 32'd1;
        end
    end

    // Count register is written every cycle so it always reflects count_next.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 32'd0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - threshold scan: step the DAC, count hits per window, report each step over tx
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int SETTLE_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       hit,
    input  logic       tx_done,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic [7:0] dac_code,
    output logic       dac_load,
    output logic       busy,
    output logic       scan_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    state_t        state;
    logic [7:0]    start_code;
    logic [7:0]    stop_code;
    logic [7:0]    window;
    logic [1:0]    cfg_idx;
    logic [SW-1:0] settle_cnt;
    logic [PW-1:0] presc;
    logic [8:0]    tick_cnt;
    logic [8:0]    win_last;
    logic [2:0]    send_idx;
    logic          in_flight;
    logic          abort_pend;
    logic          abort_req;
    logic          clr_hits;
    logic          en_hits;
    logic [31:0]   count;

    assign abort_req = rx_dv && (rx_byte == ABORT_BYTE) && (state != S_IDLE);
    // A window byte of zero stands for a full 256-tick window.
    assign win_last  = (window == 8'd0) ? 9'd255 : ({1'b0, window} - 9'd1);
    // Holding clear through SETTLE guarantees MEASURE starts from zero.
    assign clr_hits  = (state == S_SETTLE);
    assign en_hits   = (state == S_MEASURE);

    hit_counter u_hit (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_hits),
        .en    (en_hits),
        .hit   (hit),
        .count (count)
    );

    // Sequencer FSM with registered strobes; an abort in SEND is deferred until the byte on the wire finishes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            tx_dv      <= 1'b0;
            tx_byte    <= 8'h00;
            dac_code   <= 8'h00;
            dac_load   <= 1'b0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            start_code <= 8'h00;
            stop_code  <= 8'h00;
            window     <= 8'h00;
            cfg_idx    <= 2'd0;
            settle_cnt <= '0;
            presc      <= '0;
            tick_cnt   <= 9'd0;
            send_idx   <= 3'd0;
            in_flight  <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            tx_dv     <= 1'b0;
            dac_load  <= 1'b0;
            scan_done <= 1'b0;
            if (abort_req && (state != S_SEND)) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_dv && (rx_byte == ARM_BYTE)) begin
                            state   <= S_CFG;
                            busy    <= 1'b1;
                            cfg_idx <= 2'd0;
                        end
                    end
                    S_CFG: begin
                        if (rx_dv) begin
                            cfg_idx <= cfg_idx + 2'd1;
                            case (cfg_idx)
                                2'd0: start_code <= rx_byte;
                                2'd1: stop_code  <= rx_byte;
                                default: begin
                                    window   <= rx_byte;
                                    dac_code <= start_code;
                                    dac_load <= 1'b1;
                                    state    <= S_SET_DAC;
                                end
                            endcase
                        end
                    end
                    S_SET_DAC: begin
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            presc    <= '0;
                            tick_cnt <= 9'd0;
                            state    <= S_MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (presc == PRESC_LAST) begin
                            presc <= '0;
                            if (tick_cnt == win_last) begin
                                send_idx   <= 3'd0;
                                in_flight  <= 1'b0;
                                abort_pend <= 1'b0;
                                state      <= S_SEND;
                            end else begin
                                tick_cnt <= tick_cnt + 9'd1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (!in_flight) begin
                            if (abort_req) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                tx_dv     <= 1'b1;
                                tx_byte   <= result_byte(send_idx, dac_code, count);
                                in_flight <= 1'b1;
                            end
                        end else if (tx_done) begin
                            if (abort_req || abort_pend) begin
                                in_flight <= 1'b0;
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                            end else if (send_idx == 3'd4) begin
                                in_flight <= 1'b0;
                                state     <= S_NEXT;
                            end else begin
                                send_idx <= send_idx + 3'd1;
                                tx_dv    <= 1'b1;
                                tx_byte  <= result_byte(send_idx + 3'd1, dac_code, count);
                            end
                        end else if (abort_req) begin
                            abort_pend <= 1'b1;
                        end
                    end
                    S_NEXT: begin
                        // ">=" also ends a start>stop scan after its single step and stops at 0xFF without wrapping.
                        if (dac_code >= stop_code) begin
                            scan_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            dac_code <= dac_code + 8'd1;
                            dac_load <= 1'b1;
                            state    <= S_SET_DAC;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per window tick.
REQ-002 SHALL have parameter SETTLE_CYC, default 1000, clk cycles waited after each DAC load.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_dv  input  1  one-cycle strobe; rx_byte valid.
REQ-006 SHALL have port rx_byte  input  8  received command/config byte.
REQ-007 SHALL have port hit  input  1  asynchronous discriminator output; rising edges are counted.
REQ-008 SHALL have port tx_done  input  1  one-cycle strobe; transmitter finished the current byte.
REQ-009 SHALL have port tx_dv  output  1  one-cycle strobe requesting transmission of tx_byte.
REQ-010 SHALL have port tx_byte  output  8  byte to transmit; held stable until tx_done.
REQ-011 SHALL have port dac_code  output  8  threshold DAC code; held between loads.
REQ-012 SHALL have port dac_load  output  1  one-cycle strobe; DAC latches dac_code.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port scan_done  output  1  one-cycle strobe on normal scan completion.

Function
REQ-015 SHALL implement states IDLE, CFG, SET_DAC, SETTLE, MEASURE, SEND, NEXT.
REQ-016 IDLE: rx_dv with rx_byte=0xA5 SHALL go to CFG; all other bytes SHALL be ignored.
REQ-017 CFG SHALL capture the next three rx_dv bytes in order as start, stop, window, then go to SET_DAC with dac_code=start.
REQ-018 start > stop SHALL be a single-step scan at start.
REQ-019 window=0 SHALL mean 256 ticks.
REQ-020 SET_DAC SHALL drive dac_load high for exactly one cycle, then enter SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter MEASURE with the hit counter cleared.
REQ-022 hit SHALL pass a two-flop synchronizer; each synchronized 0->1 edge during MEASURE SHALL increment a 32-bit counter.
REQ-023 The hit counter SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-024 MEASURE SHALL last exactly window*TICK_DIV cycles; the tick prescaler SHALL restart at MEASURE entry.
REQ-025 SEND SHALL emit five bytes: dac_code, then count[31:24], [23:16], [15:8], [7:0].
REQ-026 SEND: first tx_dv SHALL come one cycle after SEND entry; each later tx_dv SHALL come one cycle after tx_done of the prior byte.
REQ-027 After the fifth tx_done, SEND SHALL go to NEXT.
REQ-028 NEXT: dac_code=stop SHALL pulse scan_done and go to IDLE; otherwise dac_code SHALL increment by 1 and go to SET_DAC.
REQ-029 dac_code SHALL never wrap past 0xFF; stop=0xFF SHALL terminate after code 0xFF.
REQ-030 rx_dv with 0x5A in any non-IDLE state SHALL abort.
REQ-031 Abort outside SEND SHALL go to IDLE next cycle.
REQ-032 Abort in SEND SHALL wait for tx_done of the in-flight byte, send no further bytes, then go to IDLE.
REQ-033 Abort SHALL not pulse scan_done.
REQ-034 Non-abort rx bytes outside IDLE/CFG SHALL be ignored.
REQ-035 tx_done outside SEND SHALL be ignored.

Reset
REQ-036 rst=0 at a clk edge SHALL force IDLE from any state, including mid-MEASURE and mid-SEND.
REQ-037 Reset SHALL clear tx_dv, dac_load, busy and scan_done to 0.
REQ-038 Reset SHALL clear tx_byte, dac_code, the hit counter, the prescaler and the config registers to 0x00/0.

Structure
REQ-039 The state encoding and constants 0xA5 (arm) and 0x5A (abort) SHALL live in shared package scan_pkg.
REQ-040 The synchronizer, edge detect and saturating 32-bit counter SHALL form sub-module hit_counter (ports clk, rst, clr, en, hit, count).

Verification
REQ-041 Bench SHALL cover: A5,10,12,01 with TICK_DIV=10 and 3 hits/step -> 3 steps, 15 bytes: 10,00,00,00,03 / 11,... / 12,...; scan_done once.
REQ-042 Bench SHALL cover: A5,20,10,02 -> single step at 0x20, 5 bytes, scan_done.
REQ-043 Bench SHALL cover: A5,FE,FF,01 -> codes FE, FF only; no wrap to 00.
REQ-044 Bench SHALL cover: hit held toggling for over 2^32 edges (forced counter preload FFFFFFFE) -> count byte field FF,FF,FF,FF.
REQ-045 Bench SHALL cover: 0x5A during second SEND byte -> that byte completes, no more tx_dv, busy low, no scan_done.
REQ-046 Bench SHALL cover: rst low mid-MEASURE -> next cycle IDLE, all outputs 0; following A5 sequence scans normally.
